// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: one-hot sequencer states, prefix/error byte
// values and the key event record passed on to the display stage.
package ps2_pkg;

  // One-hot state encoding for the key sequencer.
  typedef enum logic [2:0] {
    StIdle   = 3'b001,
    StDecode = 3'b010,
    StEmit   = 3'b100
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  // Key event: extended flag, break (release) flag, bare scancode.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Keyboard error / buffer overrun codes carry no key information.
  function automatic logic ps2_is_err(input logic [7:0] b);
    return (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_key_sequencer.sv
// Pops bytes from the PS/2 receiver FIFO, folds E0/F0 prefixes into the
// following scancode and emits one make/break event per key action.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ps2_ready_i         receiver FIFO non-empty
//   ps2_data_i          byte at FIFO head
//   ps2_overflow_i      receiver overflow indication
//   ps2_nextdata_n_o    active-low pop strobe, one cycle per byte
//   evt_valid_o/evt_ready_i        event handshake
//   evt_code_o/evt_ext_o/evt_break_o  event payload
//   key_held_o, held_code_o, held_ext_o  currently held key
//   press_cnt_o         accepted make events, mod 256
//   ovf_seen_o          sticky overflow flag
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_ready_i,
  input  logic [7:0] ps2_data_i,
  input  logic       ps2_overflow_i,
  output logic       ps2_nextdata_n_o,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [7:0] evt_code_o,
  output logic       evt_ext_o,
  output logic       evt_break_o,
  output logic       key_held_o,
  output logic [7:0] held_code_o,
  output logic       held_ext_o,
  output logic [7:0] press_cnt_o,
  output logic       ovf_seen_o
);

  ps2_state_e state_q;
  logic [7:0] byte_q;
  logic       ext_pend_q;
  logic       brk_pend_q;
  logic       nextdata_n_q;
  logic       evt_valid_q;
  ps2_evt_t   evt_q;
  logic       key_held_q;
  logic [7:0] held_code_q;
  logic       held_ext_q;
  logic [7:0] press_cnt_q;
  logic       ovf_seen_q;

  logic drop_repeat;
  logic brk_match;

  // Typematic repeat: a make of the key that is already down.
  assign drop_repeat = FILTER_REPEAT && !brk_pend_q && key_held_q &&
                       (ext_pend_q == held_ext_q) && (byte_q == held_code_q);

  assign brk_match = (evt_q.ext == held_ext_q) && (evt_q.code == held_code_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      byte_q       <= 8'h00;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      nextdata_n_q <= 1'b1;
      evt_valid_q  <= 1'b0;
      evt_q        <= '0;
      key_held_q   <= 1'b0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      press_cnt_q  <= 8'h00;
      ovf_seen_q   <= 1'b0;
    end else begin
      nextdata_n_q <= 1'b1;
      if (ps2_overflow_i) begin
        ovf_seen_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (ps2_ready_i) begin
            byte_q       <= ps2_data_i;
            nextdata_n_q <= 1'b0;
            state_q      <= StDecode;
          end
        end

        StDecode: begin
          state_q <= StIdle;
          if (byte_q == PS2_EXT) begin
            ext_pend_q <= 1'b1;
          end else if (byte_q == PS2_BRK) begin
            brk_pend_q <= 1'b1;
          end else if (ps2_is_err(byte_q)) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
          end else begin
            evt_q      <= '{ext: ext_pend_q, brk: brk_pend_q, code: byte_q};
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            if (!drop_repeat) begin
              evt_valid_q <= 1'b1;
              state_q     <= StEmit;
            end
          end
        end

        StEmit: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            state_q     <= StIdle;
            if (!evt_q.brk) begin
              key_held_q  <= 1'b1;
              held_code_q <= evt_q.code;
              held_ext_q  <= evt_q.ext;
              press_cnt_q <= press_cnt_q + 8'd1;
            end else if (brk_match) begin
              // Held code/ext keep their last value after release.
              key_held_q <= 1'b0;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign ps2_nextdata_n_o = nextdata_n_q;
  assign evt_valid_o      = evt_valid_q;
  assign evt_code_o       = evt_q.code;
  assign evt_ext_o        = evt_q.ext;
  assign evt_break_o      = evt_q.brk;
  assign key_held_o       = key_held_q;
  assign held_code_o      = held_code_q;
  assign held_ext_o       = held_ext_q;
  assign press_cnt_o      = press_cnt_q;
  assign ovf_seen_o       = ovf_seen_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer. Instance 0 filters typematic
// repeats, instance 1 does not. Each instance has its own byte source.
module tb_ps2_key_sequencer;
  import ps2_pkg::*;

  logic       clk;
  logic       rst;
  logic       ovf;
  logic       rdy   [2];
  logic [7:0] dat   [2];
  logic       erdy  [2];
  logic       nd_n  [2];
  logic       vld   [2];
  logic [7:0] code  [2];
  logic       ext   [2];
  logic       brk   [2];
  logic       held  [2];
  logic [7:0] hcode [2];
  logic       hext  [2];
  logic [7:0] pcnt  [2];
  logic       ovfs  [2];

  int tests;
  int fails;
  int pops     [2];
  int wide     [2];
  logic prev_low [2];
  ps2_evt_t log0[$];
  ps2_evt_t log1[$];

  ps2_key_sequencer #(.FILTER_REPEAT(1'b1)) u_dut_filt (
    .clk(clk), .rst(rst),
    .ps2_ready_i(rdy[0]), .ps2_data_i(dat[0]), .ps2_overflow_i(ovf),
    .ps2_nextdata_n_o(nd_n[0]), .evt_valid_o(vld[0]), .evt_ready_i(erdy[0]),
    .evt_code_o(code[0]), .evt_ext_o(ext[0]), .evt_break_o(brk[0]),
    .key_held_o(held[0]), .held_code_o(hcode[0]), .held_ext_o(hext[0]),
    .press_cnt_o(pcnt[0]), .ovf_seen_o(ovfs[0])
  );

  ps2_key_sequencer #(.FILTER_REPEAT(1'b0)) u_dut_raw (
    .clk(clk), .rst(rst),
    .ps2_ready_i(rdy[1]), .ps2_data_i(dat[1]), .ps2_overflow_i(ovf),
    .ps2_nextdata_n_o(nd_n[1]), .evt_valid_o(vld[1]), .evt_ready_i(erdy[1]),
    .evt_code_o(code[1]), .evt_ext_o(ext[1]), .evt_break_o(brk[1]),
    .key_held_o(held[1]), .held_code_o(hcode[1]), .held_ext_o(hext[1]),
    .press_cnt_o(pcnt[1]), .ovf_seen_o(ovfs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // Monitors sample mid-cycle: pop pulses and accepted events.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst && nd_n[i] == 1'b0) begin
        pops[i] <= pops[i] + 1;
        if (prev_low[i]) wide[i] <= wide[i] + 1;
      end
      prev_low[i] <= rst && !nd_n[i];
    end
    if (rst && vld[0] && erdy[0]) log0.push_back({ext[0], brk[0], code[0]});
    if (rst && vld[1] && erdy[1]) log1.push_back({ext[1], brk[1], code[1]});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until the DUT pops it.
  task automatic send(input int idx, input logic [7:0] b);
    bit seen;
    rdy[idx] = 1'b1;
    dat[idx] = b;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (nd_n[idx] === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL pop_timeout dut%0d byte %h: no pop in 50 cycles, want pop", idx, b);
    end
    @(posedge clk);
    #1;
    rdy[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    tests++; if (nd_n[0] !== 1'b1) begin fails++; $display("FAIL rst_nd_n: got %b want 1", nd_n[0]); end
    tests++; if (vld[0] !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", vld[0]); end
    tests++; if ({ext[0], brk[0], code[0]} !== 10'h000) begin fails++;
      $display("FAIL rst_evt: got %h want 000", {ext[0], brk[0], code[0]}); end
    tests++; if ({held[0], hext[0], hcode[0]} !== 10'h000) begin fails++;
      $display("FAIL rst_held: got %h want 000", {held[0], hext[0], hcode[0]}); end
    tests++; if (pcnt[0] !== 8'h00 || ovfs[0] !== 1'b0) begin fails++;
      $display("FAIL rst_cnt_ovf: got %h/%b want 00/0", pcnt[0], ovfs[0]); end
    rst = 1'b1;
    idle(2);
    tests++; if (pops[0] !== 0 || nd_n[1] !== 1'b1) begin fails++;
      $display("FAIL rst_no_pop: got pops %0d nd_n1 %b want 0/1", pops[0], nd_n[1]); end
  endtask

  task automatic test_make_break();
    ps2_evt_t e;
    send(0, 8'h1C);
    idle(3);
    tests++; if (log0.size() !== 1) begin fails++; $display("FAIL mb_count1: got %0d want 1", log0.size()); end
    e = '{ext: 1'b0, brk: 1'b0, code: 8'h1C};
    tests++; if (log0.size() > 0 && log0[0] !== e) begin fails++; $display("FAIL mb_make: got %h want %h", log0[0], e); end
    tests++; if (held[0] !== 1'b1 || hcode[0] !== 8'h1C) begin fails++;
      $display("FAIL mb_held1: got %b/%h want 1/1c", held[0], hcode[0]); end
    send(0, 8'hF0);
    send(0, 8'h1C);
    idle(3);
    e = '{ext: 1'b0, brk: 1'b1, code: 8'h1C};
    tests++; if (log0.size() !== 2) begin fails++; $display("FAIL mb_count2: got %0d want 2", log0.size()); end
    else if (log0[1] !== e) begin fails++; $display("FAIL mb_break: got %h want %h", log0[1], e); end
    tests++; if (held[0] !== 1'b0 || hcode[0] !== 8'h1C || pcnt[0] !== 8'd1) begin fails++;
      $display("FAIL mb_state: got held %b code %h cnt %h want 0/1c/01", held[0], hcode[0], pcnt[0]); end
  endtask

  task automatic test_extended();
    int p0;
    ps2_evt_t e;
    log0.delete();
    p0 = pops[0];
    send(0, 8'hE0);
    send(0, 8'h75);
    send(0, 8'hE0);
    send(0, 8'hF0);
    send(0, 8'h75);
    idle(3);
    tests++; if (log0.size() !== 2) begin fails++; $display("FAIL ext_count: got %0d want 2", log0.size()); end
    else begin
      e = '{ext: 1'b1, brk: 1'b0, code: 8'h75};
      if (log0[0] !== e) begin fails++; $display("FAIL ext_make: got %h want %h", log0[0], e); end
      e = '{ext: 1'b1, brk: 1'b1, code: 8'h75};
      tests++; if (log0[1] !== e) begin fails++; $display("FAIL ext_break: got %h want %h", log0[1], e); end
    end
    tests++; if (pops[0] - p0 !== 5) begin fails++; $display("FAIL ext_pops: got %0d want 5", pops[0] - p0); end
    tests++; if (wide[0] !== 0) begin fails++; $display("FAIL ext_pulse_width: got %0d wide want 0", wide[0]); end
    tests++; if (pcnt[0] !== 8'd2 || held[0] !== 1'b0) begin fails++;
      $display("FAIL ext_state: got cnt %h held %b want 02/0", pcnt[0], held[0]); end
  endtask

  task automatic test_repeat();
    log0.delete();
    log1.delete();
    send(0, 8'h1C); send(0, 8'h1C); send(0, 8'h1C); send(0, 8'hF0); send(0, 8'h1C);
    send(1, 8'h1C); send(1, 8'h1C); send(1, 8'h1C); send(1, 8'hF0); send(1, 8'h1C);
    idle(3);
    tests++; if (log0.size() !== 2 || pcnt[0] !== 8'd3) begin fails++;
      $display("FAIL rep_filter: got %0d evts cnt %h want 2/03", log0.size(), pcnt[0]); end
    tests++; if (log1.size() !== 4 || pcnt[1] !== 8'd3) begin fails++;
      $display("FAIL rep_raw: got %0d evts cnt %h want 4/03", log1.size(), pcnt[1]); end
    tests++; if (held[0] !== 1'b0 || held[1] !== 1'b0) begin fails++;
      $display("FAIL rep_held: got %b/%b want 0/0", held[0], held[1]); end
  endtask

  task automatic test_back_to_back();
    int p0;
    int bad;
    ps2_evt_t e;
    log0.delete();
    erdy[0] = 1'b0;
    send(0, 8'h1C);
    rdy[0] = 1'b1;
    dat[0] = 8'h32;
    p0 = pops[0];
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (vld[0] !== 1'b1 || code[0] !== 8'h1C || nd_n[0] !== 1'b1) bad++;
    end
    tests++; if (bad !== 0 || pops[0] !== p0) begin fails++;
      $display("FAIL stall_hold: got %0d bad cycles %0d pops want 0/0", bad, pops[0] - p0); end
    @(posedge clk);
    #1;
    erdy[0] = 1'b1;
    send(0, 8'h32);
    idle(3);
    tests++; if (log0.size() !== 2) begin fails++; $display("FAIL stall_count: got %0d want 2", log0.size()); end
    else begin
      e = '{ext: 1'b0, brk: 1'b0, code: 8'h32};
      if (log0[1] !== e) begin fails++; $display("FAIL stall_release: got %h want %h", log0[1], e); end
    end
    tests++; if (pcnt[0] !== 8'd5 || hcode[0] !== 8'h32) begin fails++;
      $display("FAIL stall_state: got cnt %h code %h want 05/32", pcnt[0], hcode[0]); end
  endtask

  task automatic test_error_ovf();
    int p0;
    ps2_evt_t e;
    log0.delete();
    tests++; if (ovfs[0] !== 1'b0) begin fails++; $display("FAIL ovf_init: got %b want 0", ovfs[0]); end
    send(0, 8'hFF);
    send(0, 8'h1C);
    ovf = 1'b1;
    idle(1);
    ovf = 1'b0;
    idle(2);
    tests++; if (log0.size() !== 1 || pcnt[0] !== 8'd6) begin fails++;
      $display("FAIL err_drop: got %0d evts cnt %h want 1/06", log0.size(), pcnt[0]); end
    tests++; if (ovfs[0] !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", ovfs[0]); end
    // Error byte cancels a pending E0; F0 E0 order folds like E0 F0.
    send(0, 8'hE0); send(0, 8'hFF); send(0, 8'h1D);
    send(0, 8'hF0); send(0, 8'hE0); send(0, 8'h1D);
    idle(10);
    tests++; if (ovfs[0] !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", ovfs[0]); end
    tests++; if (log0.size() !== 3) begin fails++; $display("FAIL err_count: got %0d want 3", log0.size()); end
    else begin
      e = '{ext: 1'b0, brk: 1'b0, code: 8'h1D};
      if (log0[1] !== e) begin fails++; $display("FAIL err_clear_pend: got %h want %h", log0[1], e); end
      e = '{ext: 1'b1, brk: 1'b1, code: 8'h1D};
      tests++; if (log0[2] !== e) begin fails++; $display("FAIL prefix_order: got %h want %h", log0[2], e); end
    end
    tests++; if (held[0] !== 1'b1 || hcode[0] !== 8'h1D || hext[0] !== 1'b0 || pcnt[0] !== 8'd7) begin
      fails++; $display("FAIL nomatch_break: got %b/%h/%b/%h want 1/1d/0/07",
                        held[0], hcode[0], hext[0], pcnt[0]); end
    // Reset while an event waits in EMIT.
    erdy[0] = 1'b0;
    send(0, 8'h2A);
    tests++; if (vld[0] !== 1'b1) begin fails++; $display("FAIL emit_before_rst: got %b want 1", vld[0]); end
    rst = 1'b0;
    #1;
    tests++; if (vld[0] !== 1'b0 || {ext[0], brk[0], code[0]} !== 10'h000 || nd_n[0] !== 1'b1) begin
      fails++; $display("FAIL rst_emit_evt: got v%b %h nd%b want v0 000 nd1",
                        vld[0], {ext[0], brk[0], code[0]}, nd_n[0]); end
    tests++; if ({held[0], hext[0], hcode[0]} !== 10'h000 || pcnt[0] !== 8'h00 || ovfs[0] !== 1'b0) begin
      fails++; $display("FAIL rst_emit_state: got %h cnt %h ovf %b want 000/00/0",
                        {held[0], hext[0], hcode[0]}, pcnt[0], ovfs[0]); end
    idle(2);
    rst = 1'b1;
    erdy[0] = 1'b1;
    p0 = pops[0];
    idle(5);
    tests++; if (pops[0] !== p0 || vld[0] !== 1'b0) begin fails++;
      $display("FAIL post_rst_quiet: got %0d pops v%b want 0/0", pops[0] - p0, vld[0]); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 255; i++) begin
      send(1, 8'h1C); send(1, 8'hF0); send(1, 8'h1C);
    end
    idle(3);
    tests++; if (pcnt[1] !== 8'hFF) begin fails++; $display("FAIL wrap_255: got %h want ff", pcnt[1]); end
    send(1, 8'h1C); send(1, 8'hF0); send(1, 8'h1C);
    idle(3);
    tests++; if (pcnt[1] !== 8'h00 || held[1] !== 1'b0) begin fails++;
      $display("FAIL wrap_256: got %h held %b want 00/0", pcnt[1], held[1]); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = 1'b0;
      dat[i] = 8'h00;
      erdy[i] = 1'b1;
      pops[i] = 0;
      wide[i] = 0;
      prev_low[i] = 1'b0;
    end
    test_reset();
    test_make_break();
    test_extended();
    test_repeat();
    test_back_to_back();
    test_error_ovf();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequences a PS/2 receiver byte FIFO into complete key events. Pops bytes with a one-cycle active-low pop pulse and folds the E0 (extended) and F0 (break) prefixes into the following scancode. Emits one make/break event per key action over a valid/ready handshake. Tracks the currently held key and a key-press counter, and sits between the PS/2 receiver and the display/ASCII stage.

## Interface
- FILTER_REPEAT, default 1: when 1, typematic repeat makes of the currently held key are discarded.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ps2_ready  in  1  receiver FIFO non-empty
- ps2_data  in  8  byte at FIFO head; valid while ps2_ready=1
- ps2_overflow  in  1  receiver overflow indication
- ps2_nextdata_n  out  1  pop strobe, active-low, one cycle per byte
- evt_valid  out  1  key event available
- evt_ready  in  1  consumer accepts event
- evt_code  out  8  scancode, excluding prefixes
- evt_ext  out  1  event carried an E0 prefix
- evt_break  out  1  1 = release, 0 = press
- key_held  out  1  a key is currently held
- held_code  out  8  scancode of the held key
- held_ext  out  1  extended flag of the held key
- press_cnt  out  8  accepted make events, mod 256
- ovf_seen  out  1  sticky: ps2_overflow was ever seen high

## Operation
States, one-hot: IDLE, DECODE, EMIT.
- **IDLE**
  - If ps2_ready=1: byte_r <= ps2_data, ps2_nextdata_n <= 0, go to DECODE.
  - Otherwise stay in IDLE.
- **DECODE** (ps2_nextdata_n is low for exactly this cycle)
  - byte_r=E0: ext_pend <= 1, go to IDLE.
  - byte_r=F0: brk_pend <= 1, go to IDLE.
  - byte_r=00 or FF (keyboard error): clear both pendings, go to IDLE, no event.
  - Any other byte: latch evt_code=byte_r, evt_ext=ext_pend, evt_break=brk_pend, then clear both pendings.
  - If FILTER_REPEAT=1, the event is a make, key_held=1 and {ext,code} equals {held_ext,held_code}: drop it, go to IDLE.
  - Otherwise go to EMIT.
- **EMIT**
  - evt_valid=1; evt_code, evt_ext and evt_break are held stable until accepted.
  - On evt_valid & evt_ready, go to IDLE and apply the updates below on the same edge.
  - Make event: key_held <= 1, held_code/held_ext <= event, press_cnt <= press_cnt+1 (wraps 255 to 0).
  - Break event matching {held_ext,held_code}: key_held <= 0; held_code and held_ext keep their last value.
  - Break event not matching: no held-state change.
- No new byte is popped while in DECODE or EMIT; backpressure on the event port stalls the FIFO.
- Repeated prefixes (E0 E0, F0 F0) are idempotent. A prefix order of F0 then E0 is equivalent to E0 then F0.
- ovf_seen <= 1 whenever ps2_overflow=1, in any state; it is cleared only by reset.

## Timing
- All outputs are registered.
- Reset values:
  - ps2_nextdata_n=1, evt_valid=0, evt_code=00, evt_ext=0, evt_break=0.
  - key_held=0, held_code=00, held_ext=0, press_cnt=00, ovf_seen=0.
  - State=IDLE, pendings cleared.
- Latency: ps2_ready sampled at edge N → pop low during cycle N+1 (DECODE) → evt_valid high from cycle N+2.
- Minimum byte spacing is 2 cycles for prefix or dropped bytes, and 3 cycles for emitted events with evt_ready tied high.
- evt_ready high in the first EMIT cycle: accepted there; IDLE on the next cycle.
- evt_ready may be high when evt_valid=0; this has no effect.
- Reset asserted in any state: the event in flight and the pending prefixes are discarded immediately; no pop occurs after reset release until ps2_ready is sampled in IDLE.

## Structure
- Shared package ps2_pkg:
  - one-hot state encoding constants;
  - PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR_LO=8'h00, PS2_ERR_HI=8'hFF;
  - a packed event struct {ext, brk, code[7:0]}, also reused by the display stage.
- Flat single module; no sub-module is warranted.

## Test plan
- Bytes 1C, F0, 1C with evt_ready=1 → two events: {0,0,1C} then {0,1,1C}; press_cnt=1; key_held=1 after the first event, 0 after the second.
- Bytes E0, 75, E0, F0, 75 → events {ext=1,make,75} then {ext=1,break,75}; exactly 5 pop pulses, each one cycle wide.
- FILTER_REPEAT=1, bytes 1C, 1C, 1C, F0, 1C → only 2 events; press_cnt=1. With FILTER_REPEAT=0 → 4 events; press_cnt=3.
- Event port stalled: evt_ready=0 for 10 cycles with 1C pending → evt_valid steady, code stable, no pop while FIFO holds 32; on release, 32 popped and emitted.
- Bytes FF, 1C and a pulse on ps2_overflow → FF dropped, single make 1C, ovf_seen=1 persisting; reset in EMIT → evt_valid=0 and all outputs at reset values.
- 256 make/break pairs → press_cnt wraps to 00.
